lru_repl_tracker: RTL

Sequential, parametrised successor to the combinational LRU eviction selector. It owns per-set LRU counters (log2(WAYS) bits per way) for an N-way set-associative cache. It services one replacement request at a time over a valid/ready handshake: hit promotion, miss victim selection with invalid-way preference, and invalidation demotion. It sits between the tag/MESI lookup stage and the line-fill logic of both the data cache (WAYS=8) and the instruction cache (WAYS=4).

---
 rtl/lru_repl_tracker_pkg.sv | 19 +
 rtl/lru_set_update.sv | 79 +++++++
 rtl/lru_repl_tracker.sv | 120 ++++++++++++
 3 files changed

// File: rtl/lru_repl_tracker_pkg.sv
// Shared types for the LRU replacement tracker.
//   lru_op_t    : request opcode carried on req_op (encoding 3 is reserved
//                 and behaves as OP_HIT).
//   lru_state_t : control FSM states of lru_repl_tracker.
package lru_repl_tracker_pkg;

  typedef enum logic [1:0] {
    OP_HIT   = 2'd0,
    OP_MISS  = 2'd1,
    OP_INVAL = 2'd2
  } lru_op_t;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_UPDATE = 2'd2
  } lru_state_t;

endpackage

// File: rtl/lru_set_update.sv
// Combinational LRU update for one set.
// Counters are WAY_W bits per way, WAYS-1 = MRU, 0 = LRU, and always form a
// permutation of 0..WAYS-1, so the increment/decrement below cannot wrap.
// Ports:
//   cnt_in     : packed counters of the set, way w at [w*WAY_W +: WAY_W]
//   op         : lru_op_t encoding (3 treated as hit)
//   way        : way for hit / invalidate
//   valid_mask : per-way line-valid bits, only consulted on a miss
//   target     : promoted, victim or demoted way
//   cnt_out    : packed counters after the update
module lru_set_update
  import lru_repl_tracker_pkg::*;
#(
  parameter int WAYS  = 8,
  parameter int WAY_W = $clog2(WAYS)
) (
  input  logic [WAYS*WAY_W-1:0] cnt_in,
  input  logic [1:0]            op,
  input  logic [WAY_W-1:0]      way,
  input  logic [WAYS-1:0]       valid_mask,
  output logic [WAY_W-1:0]      target,
  output logic [WAYS*WAY_W-1:0] cnt_out
);

  localparam logic [WAY_W-1:0] MRU = WAY_W'(WAYS - 1);

  logic             is_miss;
  logic             is_inval;
  logic             any_invalid;
  logic [WAY_W-1:0] invalid_way;
  logic [WAY_W-1:0] lru_way;
  logic [WAY_W-1:0] old_cnt;
  logic [WAY_W-1:0] cur;
  logic [WAY_W-1:0] nxt;

  // Target selection.
  // NOTE: every variable gets a default at the top of the block so no path
  // leaves it unassigned (which would infer a latch); blocking '=' is used
  // because these are combinational temporaries read later in the same block.
  always_comb begin
    is_miss     = (op == OP_MISS);
    is_inval    = (op == OP_INVAL);
    any_invalid = 1'b0;
    invalid_way = '0;
    lru_way     = '0;
    // Scan downward so the last hit is the lowest-index invalid way.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_mask[w]) begin
        any_invalid = 1'b1;
        invalid_way = WAY_W'(w);
      end
    end
    for (int w = 0; w < WAYS; w++) begin
      if (cnt_in[w*WAY_W +: WAY_W] == '0) lru_way = WAY_W'(w);
    end
    if (is_miss) target = any_invalid ? invalid_way : lru_way;
    else         target = way;
  end

  // Counter rewrite: promotion shifts younger ways down by one, demotion
  // shifts older ways up by one, keeping the set a permutation.
  always_comb begin
    old_cnt = '0;
    cur     = '0;
    nxt     = '0;
    cnt_out = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (WAY_W'(w) == target) old_cnt = cnt_in[w*WAY_W +: WAY_W];
    end
    for (int w = 0; w < WAYS; w++) begin
      cur = cnt_in[w*WAY_W +: WAY_W];
      if (WAY_W'(w) == target) nxt = is_inval ? '0 : MRU;
      else if (is_inval)       nxt = (cur < old_cnt) ? cur + 1'b1 : cur;
      else                     nxt = (cur > old_cnt) ? cur - 1'b1 : cur;
      cnt_out[w*WAY_W +: WAY_W] = nxt;
    end
  end

endmodule

// File: rtl/lru_repl_tracker.sv
// Sequential LRU replacement tracker for an N-way set-associative cache.
// After reset it sweeps every set to the identity permutation (way i = i),
// then serves one hit/miss/invalidate request per two cycles.
// Ports:
//   clk, rst                 : clock, async active-high reset
//   req_valid / req_ready    : request handshake (ready only in IDLE)
//   req_op, req_set, req_way : opcode, set index, way (ignored on miss)
//   req_valid_mask           : per-way line-valid bits for miss victim choice
//   rsp_valid / rsp_way      : registered one-cycle result pulse
//   init_done                : high once the reset sweep has finished
module lru_repl_tracker
  import lru_repl_tracker_pkg::*;
#(
  parameter int WAYS  = 8,
  parameter int SETS  = 16,
  parameter int WAY_W = $clog2(WAYS),
  parameter int SET_W = $clog2(SETS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [SET_W-1:0] req_set,
  input  logic [WAY_W-1:0] req_way,
  input  logic [WAYS-1:0]  req_valid_mask,
  output logic             rsp_valid,
  output logic [WAY_W-1:0] rsp_way,
  output logic             init_done
);

  localparam logic [SET_W-1:0] LAST_SET = SET_W'(SETS - 1);

  lru_state_t             state;
  lru_state_t             state_nxt;
  logic [SET_W-1:0]       sweep_cnt;
  logic                   accept;

  logic [1:0]             cap_op;
  logic [SET_W-1:0]       cap_set;
  logic [WAY_W-1:0]       cap_way;
  logic [WAYS-1:0]        cap_mask;

  logic [WAYS*WAY_W-1:0]  lru_mem [SETS];
  logic [WAYS*WAY_W-1:0]  init_row;
  logic [WAY_W-1:0]       upd_way;
  logic [WAYS*WAY_W-1:0]  upd_cnt;

  always_comb begin
    init_row = '0;
    for (int w = 0; w < WAYS; w++) init_row[w*WAY_W +: WAY_W] = WAY_W'(w);
  end

  // Next-state and handshake decode.
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    case (state)
      ST_INIT:   if (sweep_cnt == LAST_SET) state_nxt = ST_IDLE;
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = ST_UPDATE;
      end
      ST_UPDATE: state_nxt = ST_IDLE;
      default:   state_nxt = ST_INIT;
    endcase
  end

  assign accept = req_valid && req_ready;

  // NOTE: registered state uses non-blocking '<=' so every flop samples
  // values from before the edge, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_INIT;
      sweep_cnt <= '0;
      init_done <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_way   <= '0;
      cap_op    <= '0;
      cap_set   <= '0;
      cap_way   <= '0;
      cap_mask  <= '0;
    end else begin
      state     <= state_nxt;
      rsp_valid <= (state == ST_UPDATE);
      if (state == ST_UPDATE) rsp_way <= upd_way;
      if (state == ST_INIT) begin
        sweep_cnt <= sweep_cnt + 1'b1;
        if (sweep_cnt == LAST_SET) init_done <= 1'b1;
      end
      if (accept) begin
        cap_op   <= req_op;
        cap_set  <= req_set;
        cap_way  <= req_way;
        cap_mask <= req_valid_mask;
      end
    end
  end

  // NOTE: the counter array has no reset; the INIT sweep that follows every
  // reset writes each set, so a reset branch here would only add fan-out.
  always_ff @(posedge clk) begin
    if (state == ST_INIT)        lru_mem[sweep_cnt] <= init_row;
    else if (state == ST_UPDATE) lru_mem[cap_set]   <= upd_cnt;
  end

  lru_set_update #(
    .WAYS  (WAYS),
    .WAY_W (WAY_W)
  ) u_set_update (
    .cnt_in     (lru_mem[cap_set]),
    .op         (cap_op),
    .way        (cap_way),
    .valid_mask (cap_mask),
    .target     (upd_way),
    .cnt_out    (upd_cnt)
  );

endmodule
